if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
- Instruction-fetch controller sitting around the PC register.
- Upstream role: computes the next PC and drives the PC register's load enable.
- Downstream role: fetches the instruction at the current PC through a req/ack instruction-memory port and holds it in a one-entry IF/ID buffer with a valid/ready handshake toward decode.
- Also handles redirects (branch/jump) and discards any in-flight fetch they invalidate.

Parameters:
RESET_PC  32'h00000000  value loaded into the PC register while reset is high
PC_STEP   4             sequential PC increment in bytes

Ports:
CLK           input   1   clock; all state updates on rising edge
RST           input   1   synchronous, active-high reset
PC_in         input   32  current PC, from PC register output
NPC           output  32  next PC, to PC register data input
PC_EN         output  1   load enable to PC register
imem_req      output  1   instruction-memory request strobe, one cycle per request
imem_addr     output  32  request address
imem_ack      input   1   memory response valid; arbitrary latency of 1 or more cycles after imem_req
imem_rdata    input   32  instruction word, valid with imem_ack
redirect_valid input  1   branch/jump redirect
redirect_pc   input   32  redirect target
id_valid      output  1   IF/ID buffer holds a valid instruction
id_ready      input   1   decode consumes the buffer this cycle
id_instr      output  32  buffered instruction
id_pc         output  32  PC of buffered instruction

Behaviour:
- Timing: the PC register loads on the falling edge of CLK when PC_EN is high, so a load requested in cycle N is visible on PC_in at the rising edge ending cycle N.
- Combinational next-PC and enable:
  - NPC = RST ? RESET_PC : redirect_valid ? redirect_pc : PC_in + PC_STEP, mod 2^32 (0xFFFFFFFC + 4 wraps to 0).
  - PC_EN = RST | redirect_valid | (state == S_ADV).
- Reset, while RST is high:
  - state <= S_IDLE; id_valid, id_instr, id_pc, skid and drop flag all <= 0.
  - imem_req = 0. PC_EN = 1 and NPC = RESET_PC.
- States:
  - S_IDLE: one cycle after reset release, then S_REQ.
  - S_REQ: imem_req = 1 and imem_addr = PC_in; req_pc <= PC_in; go to S_WAIT.
  - S_WAIT: hold until imem_ack.
    - On ack with drop set: discard the word, clear drop, go to S_REQ.
    - Else if the buffer is empty or id_ready is high: buffer <= {rdata, req_pc}, id_valid <= 1, go to S_ADV.
    - Else: skid <= {rdata, req_pc}, go to S_HOLD.
  - S_HOLD: when id_ready is high, buffer <= skid, go to S_ADV.
  - S_ADV: PC_EN = 1 (sequential advance); go to S_REQ.
- Decode handshake:
  - A transfer occurs when id_valid & id_ready.
  - id_valid drops after a transfer unless the buffer is refilled in the same cycle.
  - Buffer contents are stable while id_valid & !id_ready.
- Redirect, which has priority over everything except RST:
  - id_valid <= 0 the next cycle; PC_EN = 1, NPC = redirect_pc.
  - In S_REQ or S_WAIT with no ack: drop <= 1, continue in S_WAIT.
  - In S_WAIT with ack in the same cycle: discard the word, go to S_REQ.
  - In S_HOLD or S_ADV: discard skid and advance, go to S_REQ.
  - In S_IDLE: go to S_REQ.
- imem_ack outside S_WAIT is ignored.
- RST mid-fetch aborts. The bench must not ack a request from before reset after reset release.
- Throughput: at most one instruction per 3 cycles with a 1-cycle ack (REQ, WAIT, ADV).

Decomposition:
- Shared package holds:
  - state encoding (S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ADV, 3 bits);
  - widths XLEN = 32 and INSTR_W = 32;
  - the RESET_PC default.
- Natural sub-module: if_id_buffer. It is the one-entry buffer plus skid register with its valid/ready logic. The FSM and next-PC logic stay in the top level.

Test Plan:
- Reset, RESET_PC = 0x0, memory acks 1 cycle after req → PC_EN = 1 during RST. Requests to 0x0, 0x4, 0x8 follow. id_pc sequence 0x0, 0x4, 0x8 with the matching id_instr, one every 3 cycles.
- Ack latency 4 cycles, id_ready = 1 → imem_req pulses exactly one cycle per fetch. No PC_EN until the ack. Instruction order preserved.
- id_ready = 0 for 10 cycles after first instruction → the second fetch lands in skid and the state stays S_HOLD. PC_in stays 0x4 with no new req. Releasing id_ready delivers 0x0 and then 0x4.
- Redirect to 0x100 while in S_WAIT for 0x8 → the 0x8 response is discarded with id_valid = 0. The next imem_addr is 0x100 and id_pc becomes 0x100.
- Redirect in the same cycle as ack → the word is discarded, NPC = redirect_pc, and no stale instruction reaches decode.
- PC_in = 0xFFFFFFFC, sequential advance → NPC = 0x00000000.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package if_fetch_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ADV  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/if_id_buffer.sv
// One-entry IF/ID buffer with a skid register, valid/ready toward decode.
module if_id_buffer
    import if_fetch_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               skid_load_i,
    input  logic               skid_pop_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               id_ready_i,
    output logic               id_valid_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic [XLEN-1:0]    id_pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0]    skid_pc_q, skid_pc_d;

    // Next buffer contents: consume, refill (same cycle allowed), flush wins.
    always_comb begin
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (valid_q && id_ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            instr_d = data_i;
            pc_d    = pc_i;
        end else if (skid_pop_i) begin
            valid_d = 1'b1;
            instr_d = skid_instr_q;
            pc_d    = skid_pc_q;
        end
        // Skid occupancy is implied by the controller sitting in S_HOLD.
        if (skid_load_i) begin
            skid_instr_d = data_i;
            skid_pc_d    = pc_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer and skid registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc_q         <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign id_valid_o = valid_q;
    assign id_instr_o = instr_q;
    assign id_pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: next-PC/enable generation, imem req/ack
// sequencing, redirect handling and the IF/ID buffer.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [XLEN-1:0]    PC_in,
    output logic [XLEN-1:0]    NPC,
    output logic               PC_EN,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [XLEN-1:0]    id_pc
);

    localparam logic [XLEN-1:0] PcStep = XLEN'(PC_STEP);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    logic            buf_load;
    logic            skid_load;
    logic            skid_pop;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state logic; drop marks an in-flight request orphaned by a redirect.
    always_comb begin
        state_d   = state_q;
        req_pc_d  = req_pc_q;
        drop_d    = drop_q;
        buf_load  = 1'b0;
        skid_load = 1'b0;
        skid_pop  = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                req_pc_d = PC_in;
                state_d  = S_WAIT;
                if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    if (redirect_valid || drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!id_valid || id_ready) begin
                        buf_load = 1'b1;
                        state_d  = S_ADV;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (id_ready) begin
                    skid_pop = 1'b1;
                    state_d  = S_ADV;
                end
            end
            S_ADV:   state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs toward the PC register and instruction memory.
    always_comb begin
        imem_req = 1'b0;
        PC_EN    = 1'b0;
        NPC      = PC_in + PcStep;
        if (RST) begin
            PC_EN = 1'b1;
            NPC   = RESET_PC;
        end else begin
            imem_req = (state_q == S_REQ);
            if (redirect_valid) begin
                PC_EN = 1'b1;
                NPC   = redirect_pc;
            end else begin
                PC_EN = (state_q == S_ADV);
            end
        end
    end

    assign imem_addr = PC_in;

    if_id_buffer u_if_id_buffer (
        .clk_i       (CLK),
        .rst_i       (RST),
        .flush_i     (redirect_valid),
        .load_i      (buf_load),
        .skid_load_i (skid_load),
        .skid_pop_i  (skid_pop),
        .data_i      (imem_rdata),
        .pc_i        (req_pc_q),
        .id_ready_i  (id_ready),
        .id_valid_o  (id_valid),
        .id_instr_o  (id_instr),
        .id_pc_o     (id_pc)
    );

endmodule
